dm_access_unit: RTL and testbench

Memory-stage load/store unit between the EX/MEM pipeline register and the MEM/WB register of the RV32 core. It accepts one memory-stage request at a time and drives the 128-bit DM AR/R/AW/W channels with full valid/ready handshaking. It generates byte strobes for SB/SH/SW and extracts and extends LB/LH/LW/LBU/LHU data. Non-memory instructions pass straight through to writeback. It replaces the always-ready DM wiring with a stalling FSM.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/dm_lane_align.sv | 44 ++++
 rtl/dm_access_unit.sv | 191 +++++++++++++++++++
 tb/tb_dm_access_unit.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared load/store definitions: funct3 codes, FSM states, line geometry
package mem_pkg;

  localparam int LINE_BYTES = 16;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_ADDR,
    ST_RD_DATA,
    ST_WR,
    ST_RESP
  } state_e;

  // Address bits that must be zero for the access width (byte 00, half 01, word 11).
  function automatic logic [1:0] align_mask(input logic [2:0] funct3);
    if (funct3[1]) return 2'b11;
    else if (funct3[0]) return 2'b01;
    else return 2'b00;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// rtl/dm_lane_align.sv - combinational lane steering: store replication/strobes and load extraction/extension
module dm_lane_align
  import mem_pkg::*;
(
  input  logic [2:0]              funct3,
  input  logic [3:0]              offset,
  input  logic [31:0]             store_data,
  input  logic [LINE_BYTES*8-1:0] line_rdata,
  output logic [LINE_BYTES*8-1:0] line_wdata,
  output logic [LINE_BYTES-1:0]   line_strb,
  output logic [31:0]             load_data
);

  logic [31:0] word;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    word   = line_rdata[{offset[3:2], 5'b0} +: 32];
    lane_b = word[{offset[1:0], 3'b0} +: 8];
    lane_h = word[{offset[1], 4'b0} +: 16];

    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'b0, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'b0, lane_h};
      default: load_data = word;
    endcase

    // Replicating the store data means every candidate lane already holds it; the strobe picks one.
    if (funct3[1]) begin
      line_wdata = {(LINE_BYTES / 4){store_data}};
      line_strb  = LINE_BYTES'(4'hF) << offset;
    end else if (funct3[0]) begin
      line_wdata = {(LINE_BYTES / 2){store_data[15:0]}};
      line_strb  = LINE_BYTES'(4'h3) << offset;
    end else begin
      line_wdata = {LINE_BYTES{store_data[7:0]}};
      line_strb  = LINE_BYTES'(4'h1) << offset;
    end
  end

endmodule

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - memory-stage load/store FSM driving the 128-bit DM channels
// Optional: MISALIGN_TRAP_EN traps misaligned half/word accesses instead of force-aligning them.
module dm_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_load,
  input  logic                req_store,
  input  logic [2:0]          req_funct3,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [31:0]         req_wdata,
  input  logic [4:0]          req_rd,
  input  logic                req_we,
  output logic [ADDR_W-1:0]   ARADDR_DM,
  output logic                ARVALID_DM,
  input  logic                ARREADY_DM,
  input  logic [LINE_W-1:0]   RDATA_DM,
  input  logic                RVALID_DM,
  output logic                RREADY_DM,
  output logic [ADDR_W-1:0]   AWADDR_DM,
  output logic                AWVALID_DM,
  input  logic                AWREADY_DM,
  output logic [LINE_W-1:0]   WDATA_DM,
  output logic [LINE_W/8-1:0] WSTRB_DM,
  output logic                WVALID_DM,
  input  logic                WREADY_DM,
  output logic                wb_valid,
  output logic                wb_we,
  output logic [4:0]          wb_rd,
  output logic [31:0]         wb_data
`ifdef MISALIGN_TRAP_EN
  ,
  output logic                wb_misalign
`endif
);

  state_e              state_q, state_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [4:0]          rd_q, rd_d;
  logic                we_q, we_d;
  logic [31:0]         wb_data_q, wb_data_d;
  logic                aw_pend_q, aw_pend_d;
  logic                w_pend_q, w_pend_d;
  logic [1:0]          amask;
  logic [LINE_W-1:0]   line_wdata;
  logic [LINE_W/8-1:0] line_strb;
  logic [31:0]         load_data;
`ifdef MISALIGN_TRAP_EN
  logic                misalign_q, misalign_d;
  logic                mis;
`endif

  dm_lane_align u_lane_align (
    .funct3     (funct3_q),
    .offset     (addr_q[3:0]),
    .store_data (wdata_q),
    .line_rdata (RDATA_DM),
    .line_wdata (line_wdata),
    .line_strb  (line_strb),
    .load_data  (load_data)
  );

  assign amask = align_mask(req_funct3);
`ifdef MISALIGN_TRAP_EN
  assign mis = (req_load || req_store) && (|(req_addr[1:0] & amask));
`endif

  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rd_d      = rd_q;
    we_d      = we_q;
    wb_data_d = wb_data_q;
    aw_pend_d = aw_pend_q;
    w_pend_d  = w_pend_q;
`ifdef MISALIGN_TRAP_EN
    misalign_d = misalign_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          funct3_d  = req_funct3;
          wdata_d   = req_wdata;
          rd_d      = req_rd;
          we_d      = req_we && !req_store;
          wb_data_d = 32'(req_addr);
          addr_d    = req_addr;
          if (req_load || req_store) begin
            addr_d = {req_addr[ADDR_W-1:2], req_addr[1:0] & ~amask};
          end
`ifdef MISALIGN_TRAP_EN
          misalign_d = mis;
          if (mis) begin
            we_d      = 1'b0;
            wb_data_d = '0;
            state_d   = ST_RESP;
          end else
`endif
          if (req_load) begin
            state_d = ST_RD_ADDR;
          end else if (req_store) begin
            aw_pend_d = 1'b1;
            w_pend_d  = 1'b1;
            state_d   = ST_WR;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RD_ADDR: begin
        if (ARREADY_DM) state_d = ST_RD_DATA;
      end
      ST_RD_DATA: begin
        if (RVALID_DM) begin
          wb_data_d = load_data;
          state_d   = ST_RESP;
        end
      end
      ST_WR: begin
        // AW and W complete independently; leave only once both are done.
        aw_pend_d = aw_pend_q && !AWREADY_DM;
        w_pend_d  = w_pend_q && !WREADY_DM;
        if (!aw_pend_d && !w_pend_d) state_d = ST_RESP;
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      funct3_q  <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rd_q      <= '0;
      we_q      <= 1'b0;
      wb_data_q <= '0;
      aw_pend_q <= 1'b0;
      w_pend_q  <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rd_q      <= rd_d;
      we_q      <= we_d;
      wb_data_q <= wb_data_d;
      aw_pend_q <= aw_pend_d;
      w_pend_q  <= w_pend_d;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= misalign_d;
`endif
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign ARVALID_DM = (state_q == ST_RD_ADDR);
  assign ARADDR_DM  = ARVALID_DM ? {addr_q[ADDR_W-1:4], 4'b0} : '0;
  assign RREADY_DM  = (state_q == ST_RD_DATA);
  assign AWVALID_DM = aw_pend_q;
  assign AWADDR_DM  = aw_pend_q ? {addr_q[ADDR_W-1:4], 4'b0} : '0;
  assign WVALID_DM  = w_pend_q;
  assign WDATA_DM   = w_pend_q ? line_wdata : '0;
  assign WSTRB_DM   = w_pend_q ? line_strb : '0;
  assign wb_valid   = (state_q == ST_RESP);
  assign wb_we      = wb_valid && we_q;
  assign wb_rd      = wb_valid ? rd_q : '0;
  assign wb_data    = wb_valid ? wb_data_q : '0;
`ifdef MISALIGN_TRAP_EN
  assign wb_misalign = wb_valid && misalign_q;
`endif

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - directed plus randomized bench with a byte-array reference model
module tb_dm_access_unit;
  import mem_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req_valid, req_ready, req_load, req_store, req_we;
  logic [2:0]   req_funct3;
  logic [31:0]  req_addr, req_wdata;
  logic [4:0]   req_rd;
  logic [31:0]  ARADDR_DM, AWADDR_DM;
  logic         ARVALID_DM, ARREADY_DM, RVALID_DM, RREADY_DM;
  logic         AWVALID_DM, AWREADY_DM, WVALID_DM, WREADY_DM;
  logic [127:0] RDATA_DM, WDATA_DM;
  logic [15:0]  WSTRB_DM;
  logic         wb_valid, wb_we;
  logic [4:0]   wb_rd;
  logic [31:0]  wb_data;
`ifdef MISALIGN_TRAP_EN
  logic         wb_misalign;
`endif

  int checks = 0;
  int errors = 0;
  logic [7:0]   line_b [16];
  logic [31:0]  last_wb;
  logic [31:0]  last_awaddr;
  logic [15:0]  last_strb;
  logic [127:0] last_wdata;

  always #5 clk = ~clk;

  dm_access_unit dut (
    .clk(clk), .rst(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load), .req_store(req_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .req_we(req_we),
    .ARADDR_DM(ARADDR_DM), .ARVALID_DM(ARVALID_DM), .ARREADY_DM(ARREADY_DM),
    .RDATA_DM(RDATA_DM), .RVALID_DM(RVALID_DM), .RREADY_DM(RREADY_DM),
    .AWADDR_DM(AWADDR_DM), .AWVALID_DM(AWVALID_DM), .AWREADY_DM(AWREADY_DM),
    .WDATA_DM(WDATA_DM), .WSTRB_DM(WSTRB_DM), .WVALID_DM(WVALID_DM), .WREADY_DM(WREADY_DM),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data)
`ifdef MISALIGN_TRAP_EN
    , .wb_misalign(wb_misalign)
`endif
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1]) return 4;
    if (f3[0]) return 2;
    return 1;
  endfunction

  function automatic int offset_of(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    return (int'(addr[3:0]) / sz) * sz;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [2:0] f3);
    int sz = size_of(f3);
    int off = offset_of(addr, f3);
    longint unsigned v = 0;
    for (int i = 0; i < sz; i++) v = v + (longint'(line_b[off + i]) << (8 * i));
    if (!f3[2] && sz < 4 && v[8 * sz - 1]) v = v + (64'hFFFF_FFFF_FFFF_FFFF << (8 * sz));
    return v[31:0];
  endfunction

  function automatic logic [127:0] packed_line();
    logic [127:0] l;
    for (int i = 0; i < 16; i++) l[8 * i +: 8] = line_b[i];
    return l;
  endfunction

  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd, input logic we);
    check("req_ready_before_accept", req_ready, 1'b1);
    req_valid = 1'b1; req_load = ld; req_store = st; req_funct3 = f3;
    req_addr = addr; req_wdata = wd; req_rd = rd; req_we = we;
    @(negedge clk);
    req_valid = 1'b0; req_load = 1'b0; req_store = 1'b0; req_addr = $urandom;
  endtask

  task automatic do_alu(input logic [31:0] addr, input logic [4:0] rd, input logic we);
    issue(1'b0, 1'b0, 3'($urandom), addr, $urandom, rd, we);
    check("alu_wb_valid", wb_valid, 1'b1);
    check("alu_wb_data", wb_data, addr);
    check("alu_wb_rd", wb_rd, rd);
    check("alu_wb_we", wb_we, we);
    check("alu_no_dm_valid", {ARVALID_DM, AWVALID_DM, WVALID_DM}, 3'b000);
    check("alu_busy_in_resp", req_ready, 1'b0);
    @(negedge clk);
    check("alu_wb_pulse_end", wb_valid, 1'b0);
  endtask

  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                         input logic we, input int d_ar, input int d_r);
    logic [31:0] exp_data;
    exp_data = model_load(addr, f3);
    issue(1'b1, 1'b0, f3, addr, $urandom, rd, we);
    for (int k = 0; k <= d_ar; k++) begin
      check("ld_arvalid", ARVALID_DM, 1'b1);
      check("ld_araddr", ARADDR_DM, {addr[31:4], 4'b0});
      check("ld_no_wr", {AWVALID_DM, WVALID_DM, wb_valid}, 3'b000);
      ARREADY_DM = (k == d_ar);
      @(negedge clk);
    end
    ARREADY_DM = 1'b0;
    for (int k = 0; k <= d_r; k++) begin
      check("ld_rready", RREADY_DM, 1'b1);
      check("ld_arvalid_dropped", ARVALID_DM, 1'b0);
      RDATA_DM  = packed_line();
      RVALID_DM = (k == d_r);
      @(negedge clk);
    end
    RVALID_DM = 1'b0;
    RDATA_DM  = {$urandom, $urandom, $urandom, $urandom};
    check("ld_wb_valid", wb_valid, 1'b1);
    check("ld_wb_data", wb_data, exp_data);
    check("ld_wb_rd", wb_rd, rd);
    check("ld_wb_we", wb_we, we);
    last_wb = wb_data;
    @(negedge clk);
    check("ld_wb_pulse_end", wb_valid, 1'b0);
  endtask

  task automatic do_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd,
                          input logic [4:0] rd, input int d_aw, input int d_w);
    logic [15:0]  exp_strb;
    logic [127:0] exp_wdata;
    int sz, off, n;
    sz  = size_of(f3);
    off = offset_of(addr, f3);
    for (int i = 0; i < 16; i++) begin
      exp_strb[i]          = (i >= off) && (i < off + sz);
      exp_wdata[8 * i +: 8] = 8'(wd >> (8 * (i % sz)));
    end
    n = (d_aw > d_w) ? d_aw : d_w;
    issue(1'b0, 1'b1, f3, addr, wd, rd, 1'b1);
    last_awaddr = AWADDR_DM;
    last_strb   = WSTRB_DM;
    last_wdata  = WDATA_DM;
    for (int c = 0; c <= n; c++) begin
      check("st_awvalid", AWVALID_DM, c <= d_aw);
      check("st_wvalid", WVALID_DM, c <= d_w);
      check("st_no_rd", {ARVALID_DM, wb_valid}, 2'b00);
      if (c <= d_aw) check("st_awaddr", AWADDR_DM, {addr[31:4], 4'b0});
      if (c <= d_w) begin
        check("st_wdata", WDATA_DM, exp_wdata);
        check("st_wstrb", WSTRB_DM, exp_strb);
      end else begin
        check("st_wstrb_idle", WSTRB_DM, 16'h0);
      end
      AWREADY_DM = (c == d_aw);
      WREADY_DM  = (c == d_w);
      @(negedge clk);
    end
    AWREADY_DM = 1'b0;
    WREADY_DM  = 1'b0;
    check("st_wb_valid", wb_valid, 1'b1);
    check("st_wb_we", wb_we, 1'b0);
    check("st_valids_dropped", {AWVALID_DM, WVALID_DM}, 2'b00);
    @(negedge clk);
    check("st_wb_pulse_end", wb_valid, 1'b0);
  endtask

  initial begin
    logic [2:0] f3;
    int kind;
    rst_n = 1'b0;
    req_valid = 0; req_load = 0; req_store = 0; req_funct3 = 0; req_addr = 0;
    req_wdata = 0; req_rd = 0; req_we = 0;
    ARREADY_DM = 0; RVALID_DM = 0; RDATA_DM = '0; AWREADY_DM = 0; WREADY_DM = 0;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 1'b1);
    check("rst_valids", {ARVALID_DM, RREADY_DM, AWVALID_DM, WVALID_DM, wb_valid, wb_we}, 6'b0);
    check("rst_addr_strb", {ARADDR_DM, AWADDR_DM, WSTRB_DM}, 80'h0);
    check("rst_wb", {wb_rd, wb_data, WDATA_DM}, 165'h0);
    rst_n = 1'b1;
    @(negedge clk);

    do_alu(32'h0000_1234, 5'd5, 1'b1);

    for (int i = 0; i < 16; i++) line_b[i] = 8'($urandom);
    line_b[7] = 8'h80;
    do_load(32'h0000_0107, F3_B, 5'd6, 1'b1, 0, 0);
    check("lb_const", last_wb, 32'hFFFF_FF80);
    do_load(32'h0000_0107, F3_BU, 5'd6, 1'b1, 0, 0);
    check("lbu_const", last_wb, 32'h0000_0080);

    do_store(32'h0000_020A, F3_H, 32'h1234_BEEF, 5'd7, 0, 0);
    check("sh_awaddr_const", last_awaddr, 32'h0000_0200);
    check("sh_wstrb_const", last_strb, 16'h0C00);
    check("sh_wdata_const", last_wdata, {8{16'hBEEF}});

    do_store(32'h0000_0344, F3_W, 32'hCAFE_F00D, 5'd8, 0, 3);

    issue(1'b1, 1'b0, F3_W, 32'h0000_0040, 32'h0, 5'd3, 1'b1);
    for (int k = 0; k < 3; k++) begin
      check("rstx_arvalid_held", ARVALID_DM, 1'b1);
      @(negedge clk);
    end
    ARREADY_DM = 1'b1;
    @(negedge clk);
    ARREADY_DM = 1'b0;
    check("rstx_in_rd_data", RREADY_DM, 1'b1);
    rst_n = 1'b0;
    #1;
    check("rstx_valids_drop", {ARVALID_DM, RREADY_DM, AWVALID_DM, WVALID_DM, wb_valid}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rstx_no_wb", wb_valid, 1'b0);
      check("rstx_ready", req_ready, 1'b1);
    end

    for (int i = 0; i < 16; i++) line_b[i] = 8'($urandom);
    do_load(32'h0000_0002, F3_W, 5'd9, 1'b1, 0, 0);
    check("lw_force_align", last_wb, {line_b[3], line_b[2], line_b[1], line_b[0]});

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 2);
      for (int i = 0; i < 16; i++) line_b[i] = 8'($urandom);
      if (kind == 0) begin
        do_alu($urandom, 5'($urandom), 1'($urandom));
      end else if (kind == 1) begin
        case ($urandom_range(0, 4))
          0: f3 = F3_B;
          1: f3 = F3_H;
          2: f3 = F3_W;
          3: f3 = F3_BU;
          default: f3 = F3_HU;
        endcase
        do_load($urandom, f3, 5'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        case ($urandom_range(0, 2))
          0: f3 = F3_B;
          1: f3 = F3_H;
          default: f3 = F3_W;
        endcase
        do_store($urandom, f3, $urandom, 5'($urandom), $urandom_range(0, 3), $urandom_range(0, 3));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
